// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared definitions for the sequential digit multiplier.
//   STATE_W  - width of the FSM state code driven to the seven-segment display
//   state_t  - FSM state type; code 3 is unused and recovers to ST_IDLE
package seq_mult_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/digit_mult.sv
// digit_mult: combinational DIGIT x DIGIT unsigned multiplier.
// Ports:
//   x, y : DIGIT-bit unsigned digits
//   p    : 2*DIGIT-bit unsigned product
module digit_mult #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0]   x,
    input  logic [DIGIT-1:0]   y,
    output logic [2*DIGIT-1:0] p
);

    assign p = (2*DIGIT)'(x) * (2*DIGIT)'(y);

endmodule

// File: rtl/seq_mult_param.sv
// seq_mult_param: sequential multiplier, one DIGIT x DIGIT partial product
// per cycle over ND*ND cycles (ND = WIDTH/DIGIT).
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous reset, active low
//   start        - operation request, only looked at in IDLE
//   signed_mode  - two's complement operands (only with SEQ_MULT_SIGNED_EN)
//   a, b         - operands, captured on the accepted start
//   d_out        - product accumulator, final product valid while done_flag=1
//   locked       - operand registers frozen (CALC and DONE)
//   done_flag    - one-cycle completion pulse (DONE state)
//   state        - current FSM state code
//   verif_a/b    - captured operands (magnitudes in signed mode)
// Build option: define SEQ_MULT_SIGNED_EN to add signed_mode.
//
// State table
//   state   | meaning
//   ST_IDLE | waiting for start, d_out holds last result
//   ST_CALC | one partial product per cycle, b-digit outer, a-digit inner
//   ST_DONE | final product on d_out, done_flag high for one cycle
module seq_mult_param
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic               signed_mode,
`endif
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] d_out,
    output logic               locked,
    output logic               done_flag,
    output logic [STATE_W-1:0] state,
    output logic [WIDTH-1:0]   verif_a,
    output logic [WIDTH-1:0]   verif_b
);

    localparam int ND    = WIDTH / DIGIT;
    localparam int IDX_W = (ND > 1) ? $clog2(ND) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ND - 1);

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    a_q, b_q;
    logic [IDX_W-1:0]    i_q, j_q;
    logic [DIGIT-1:0]    a_dig, b_dig;
    logic [2*DIGIT-1:0]  pp;
    logic [31:0]         shamt;
    logic [2*WIDTH-1:0]  acc_sum;
    logic                last;
    logic [WIDTH-1:0]    a_cap, b_cap;

`ifdef SEQ_MULT_SIGNED_EN
    logic neg_q;
    logic neg_d;
    // Magnitudes fit in WIDTH bits unsigned, including the most negative value.
    assign a_cap = (signed_mode && a[WIDTH-1]) ? -a : a;
    assign b_cap = (signed_mode && b[WIDTH-1]) ? -b : b;
    assign neg_d = signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
`else
    assign a_cap = a;
    assign b_cap = b;
`endif

    assign a_dig = DIGIT'(a_q >> (32'(j_q) * 32'(DIGIT)));
    assign b_dig = DIGIT'(b_q >> (32'(i_q) * 32'(DIGIT)));

    digit_mult #(.DIGIT(DIGIT)) u_digit_mult (
        .x (a_dig),
        .y (b_dig),
        .p (pp)
    );

    assign shamt   = 32'(DIGIT) * (32'(i_q) + 32'(j_q));
    assign acc_sum = d_out + ((2*WIDTH)'(pp) << shamt);
    assign last    = (i_q == IDX_LAST) && (j_q == IDX_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_CALC;
            ST_CALC: if (last)  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            i_q   <= '0;
            j_q   <= '0;
            d_out <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q   <= a_cap;
                        b_q   <= b_cap;
                        i_q   <= '0;
                        j_q   <= '0;
                        d_out <= '0;
`ifdef SEQ_MULT_SIGNED_EN
                        neg_q <= neg_d;
`endif
                    end
                end
                ST_CALC: begin
                    d_out <= acc_sum;
`ifdef SEQ_MULT_SIGNED_EN
                    // Sign fix-up folded into the last commit so DONE already shows it.
                    if (last && neg_q) d_out <= -acc_sum;
`endif
                    if (j_q == IDX_LAST) begin
                        j_q <= '0;
                        i_q <= (i_q == IDX_LAST) ? '0 : i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state     = state_q;
    assign done_flag = (state_q == ST_DONE);
    assign locked    = (state_q == ST_CALC) || (state_q == ST_DONE);
    assign verif_a   = a_q;
    assign verif_b   = b_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: self-checking bench for seq_mult_param at WIDTH=16 and
// WIDTH=8 (DIGIT=4). Signed vectors are included when SEQ_MULT_SIGNED_EN is set.
module tb_seq_mult_param;

    typedef struct {
        bit          is8;
        bit          sm;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start16, start8;
    logic [15:0] a16, b16;
    logic [7:0]  a8, b8;
    logic [31:0] d16;
    logic [15:0] d8;
    logic        locked16, locked8, done16, done8;
    logic [1:0]  state16, state8;
    logic [15:0] va16, vb16;
    logic [7:0]  va8, vb8;
`ifdef SEQ_MULT_SIGNED_EN
    logic        sm;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_mult_param #(.WIDTH(16), .DIGIT(4)) u16 (
        .clk(clk), .rst(rst), .start(start16),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_mode(sm),
`endif
        .a(a16), .b(b16), .d_out(d16), .locked(locked16), .done_flag(done16),
        .state(state16), .verif_a(va16), .verif_b(vb16)
    );

    seq_mult_param #(.WIDTH(8), .DIGIT(4)) u8 (
        .clk(clk), .rst(rst), .start(start8),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_mode(sm),
`endif
        .a(a8), .b(b8), .d_out(d8), .locked(locked8), .done_flag(done8),
        .state(state8), .verif_a(va8), .verif_b(vb8)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input string nm);
        int          n;
        bit          seen;
        logic [31:0] res;
        int          lat;
        lat  = v.is8 ? 5 : 17;
        res  = 'x;
        seen = 1'b0;
        n    = 0;
        @(negedge clk);
`ifdef SEQ_MULT_SIGNED_EN
        sm = v.sm;
`endif
        if (v.is8) begin a8 = v.a[7:0]; b8 = v.b[7:0]; start8 = 1'b1; end
        else       begin a16 = v.a;     b16 = v.b;     start16 = 1'b1; end
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                start8  = 1'b0;
                start16 = 1'b0;
                chk({nm, " locked"}, v.is8 ? locked8 : locked16, 1);
            end
            if (v.is8 ? done8 : done16) begin
                seen = 1'b1;
                res  = v.is8 ? {16'h0, d8} : d16;
            end
        end
        chk({nm, " latency"}, n, lat);
        chk({nm, " product"}, res, v.exp);
        repeat (3) @(posedge clk);
        #1;
        chk({nm, " idle state"}, v.is8 ? state8 : state16, 0);
        chk({nm, " held"}, v.is8 ? {16'h0, d8} : d16, v.exp);
    endtask

    vec_t vecs[$];

    initial begin
        int          dones;
        int          done_at;
        int          e1, e2;
        logic [31:0] res;
        vec_t        v;

        // {is8, signed_mode, a, b, expected product}
        vecs.push_back('{1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001});
        vecs.push_back('{1'b0, 1'b0, 16'h0000, 16'h0000, 32'h00000000});
        vecs.push_back('{1'b0, 1'b0, 16'h1234, 16'h0010, 32'h00012340});
        vecs.push_back('{1'b0, 1'b0, 16'h00FF, 16'h0100, 32'h0000FF00});
        vecs.push_back('{1'b0, 1'b0, 16'h8000, 16'h0002, 32'h00010000});
        vecs.push_back('{1'b0, 1'b0, 16'hABCD, 16'h0001, 32'h0000ABCD});
        vecs.push_back('{1'b1, 1'b0, 16'h00FF, 16'h00FF, 32'h0000FE01});
        vecs.push_back('{1'b1, 1'b0, 16'h0000, 16'h00A5, 32'h00000000});
        vecs.push_back('{1'b1, 1'b0, 16'h000F, 16'h0011, 32'h000000FF});
        vecs.push_back('{1'b1, 1'b0, 16'h0012, 16'h0034, 32'h000003A8});
`ifdef SEQ_MULT_SIGNED_EN
        vecs.push_back('{1'b1, 1'b1, 16'h00FD, 16'h0005, 32'h0000FFF1});
        vecs.push_back('{1'b1, 1'b1, 16'h0080, 16'h0080, 32'h00004000});
        vecs.push_back('{1'b1, 1'b1, 16'h007F, 16'h00FF, 32'h0000FF81});
        vecs.push_back('{1'b1, 1'b0, 16'h00FD, 16'h0005, 32'h000004F1});
        sm = 1'b0;
`endif

        rst = 1'b0; start16 = 1'b0; start8 = 1'b0;
        a16 = '0; b16 = '0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset d_out16", d16, 0);
        chk("reset state16", state16, 0);
        chk("reset locked16", locked16, 0);
        chk("reset done16", done16, 0);
        chk("reset verif_a16", va16, 0);
        chk("reset d_out8", d8, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < vecs.size(); k++)
            run_op(vecs[k], $sformatf("vec%0d", k));

        // start and new operands during CALC are ignored
        @(negedge clk);
        a16 = 16'h1234; b16 = 16'h0010; start16 = 1'b1;
        dones = 0; done_at = 0; res = 'x;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (k == 1) start16 = 1'b0;
            if (k == 3) begin start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF; end
            if (k == 4) start16 = 1'b0;
            if (k == 10) chk("ignore verif_a", va16, 16'h1234);
            if (done16) begin dones++; done_at = k; res = d16; end
        end
        chk("ignore done count", dones, 1);
        chk("ignore done edge", done_at, 17);
        chk("ignore product", res, 32'h00012340);

        // reset mid-CALC aborts the operation
        @(negedge clk);
        a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 1) start16 = 1'b0;
        end
        rst = 1'b0;
        #1;
        chk("abort d_out", d16, 0);
        chk("abort state", state16, 0);
        chk("abort done", done16, 0);
        chk("abort locked", locked16, 0);
        @(negedge clk);
        rst = 1'b1;
        dones = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done16) dones++;
        end
        chk("abort no done", dones, 0);
        v = '{1'b0, 1'b0, 16'h0003, 16'h0004, 32'h0000000C};
        run_op(v, "after abort");

        // start held high: back-to-back operations
        @(negedge clk);
        a16 = 16'h00FF; b16 = 16'h0101; start16 = 1'b1;
        e1 = 0; e2 = 0;
        for (int k = 1; k <= 60 && e2 == 0; k++) begin
            @(posedge clk); #1;
            if (done16) begin
                chk("b2b product", d16, 32'h0000FFFF);
                if (e1 == 0) e1 = k;
                else begin e2 = k; start16 = 1'b0; end
            end
        end
        chk("b2b first done", e1, 17);
        chk("b2b period", e2 - e1, 18);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b idle", state16, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_mult_param.md
SEQ_MULT_PARAM -- requirements
Module: seq_mult_param

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits, a multiple of DIGIT, at least 2*DIGIT.
REQ-002 SHALL have parameter DIGIT, default 4: digit width of the per-cycle partial-product multiplier; ND = WIDTH/DIGIT.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous reset, active-low.
REQ-005 SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-006 SHALL have ports a and b, input, WIDTH bits each: operands, captured on the accepted start.
REQ-007 SHALL have port d_out, output, 2*WIDTH bits: product accumulator.
REQ-008 SHALL have port locked, output, 1 bit: high while operand registers are frozen (CALC and DONE).
REQ-009 SHALL have port done_flag, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port state, output, 2 bits: current FSM state code for the seven-segment driver.
REQ-011 SHALL have ports verif_a and verif_b, output, WIDTH bits each: captured operands for bench checking.

Function
REQ-012 SHALL implement the FSM states IDLE=0, CALC=1 and DONE=2; code 3 is unreachable and SHALL recover to IDLE.
REQ-013 SHALL, in IDLE with start=1 at a clock edge, capture a and b, clear d_out to 0 and enter CALC.
REQ-014 SHALL, in CALC, perform exactly one partial product per cycle over ND*ND cycles, with b-digit i as the outer index and a-digit j as the inner index, both ascending from 0.
REQ-015 SHALL, on each CALC cycle, add (a_j*b_i) << DIGIT*(i+j) to d_out modulo 2^(2*WIDTH); no carry is lost for an in-range product.
REQ-016 SHALL advance from CALC to DONE on the edge that commits the last partial product (i=j=ND-1).
REQ-017 SHALL stay in DONE for exactly one cycle with done_flag=1 and d_out equal to the final product, then return to IDLE.
REQ-018 SHALL give a latency from the start edge to the done_flag cycle of ND*ND+1 edges: 17 at defaults, 5 at WIDTH=8.
REQ-019 SHALL hold d_out in IDLE until the next accepted start.
REQ-020 SHALL ignore start in CALC and DONE; a start still held high in IDLE after DONE SHALL be accepted as a new operation.
REQ-021 SHALL hold the captured operands constant while locked=1; changes on a and b SHALL have no effect.
REQ-022 SHALL produce a correct product for operands of 0, including all-zero digits, with no early termination.

Reset
REQ-023 SHALL, on rst=0, asynchronously force: state=IDLE, d_out=0, locked=0, done_flag=0, verif_a=0, verif_b=0, and both digit indices=0.
REQ-024 SHALL treat reset asserted mid-CALC as an abort: no done_flag is produced, and the first start after release begins a fresh operation.

Configuration
REQ-025 SHALL, when SEQ_MULT_SIGNED_EN is defined, add an input port signed_mode (1 bit) that is captured with the operands.
REQ-026 SHALL, with the macro defined and signed_mode=1, treat a and b as two's complement: capture their magnitudes, and negate d_out in DONE when the sign bits differ; the result is valid in the done_flag cycle and latency is unchanged.
REQ-027 SHALL, without the macro, have no signed_mode port and perform unsigned multiplication only.

Structure
REQ-028 SHALL place the FSM state type and its encodings, the ST_IDLE/ST_CALC/ST_DONE constants, and the state output width in shared package seq_mult_pkg.
REQ-029 SHALL instantiate one combinational sub-module, digit_mult (DIGIT x DIGIT -> 2*DIGIT unsigned); digit selection, shift and accumulation stay in seq_mult_param.

Verification
REQ-030 SHALL check, at defaults, a=0xFFFF and b=0xFFFF -> done_flag on edge 17 with d_out=0xFFFE0001, held in IDLE.
REQ-031 SHALL check, at WIDTH=8/DIGIT=4, a=0xFF and b=0xFF -> done_flag on edge 5 with d_out=0xFE01; and a=0x00 with b=0xA5 -> d_out=0x0000.
REQ-032 SHALL check that a start pulse and changed a/b at CALC cycle 3 leave the result 0x1234*0x0010=0x00012340 with a single done_flag.
REQ-033 SHALL check that rst=0 at CALC cycle 7 gives d_out=0, state=0 and no done_flag; a new start with 3*4 then yields 0x0000000C.
REQ-034 SHALL check, with SEQ_MULT_SIGNED_EN and WIDTH=8, signed_mode=1: a=0xFD(-3), b=0x05 -> d_out=0xFFF1; and a=0x80, b=0x80 -> d_out=0x4000.
REQ-035 SHALL check that start held high continuously gives back-to-back operations with done_flag every 18 cycles at defaults (17 edges plus the IDLE accept cycle).
